// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg
// Purpose: shared definitions for the wb_timer peripheral -- register word
//          indices, CTRL/STATUS bit positions, the CTRL register layout and
//          the reset value of the 64-bit compare register.
// Ports:   none (package).
package wb_timer_pkg;

  // Word index within the 8-word register window (byte address bits [4:2]).
  typedef enum logic [2:0] {
    IDX_CTRL     = 3'd0,
    IDX_PRESC    = 3'd1,
    IDX_COUNT_LO = 3'd2,
    IDX_COUNT_HI = 3'd3,
    IDX_CMP_LO   = 3'd4,
    IDX_CMP_HI   = 3'd5,
    IDX_STATUS   = 3'd6,
    IDX_RSVD     = 3'd7
  } reg_idx_e;

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_IRQ_EN_BIT      = 1;
  localparam int CTRL_AUTO_RELOAD_BIT = 2;
  localparam int STATUS_MATCH_BIT     = 0;

  // CMP resets to all ones so a freshly reset timer does not match until
  // the count has run through the whole 64-bit range.
  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Field order puts EN in bit 0, IRQ_EN in bit 1, AUTO_RELOAD in bit 2.
  typedef struct packed {
    logic auto_reload;
    logic irq_en;
    logic en;
  } ctrl_t;

  // CTRL as seen on the bus: unused bits read as zero.
  function automatic logic [31:0] ctrl_word(input ctrl_t ctrl);
    logic [31:0] word;
    word = '0;
    word[CTRL_EN_BIT]          = ctrl.en;
    word[CTRL_IRQ_EN_BIT]      = ctrl.irq_en;
    word[CTRL_AUTO_RELOAD_BIT] = ctrl.auto_reload;
    return word;
  endfunction

endpackage

// File: rtl/wb_timer_if.sv
// wb_timer_if
// Purpose: Wishbone-style slave port used by the NIC slave slots (same shape
//          as the UART slave): select, cycle, write strobe, word address,
//          write data, registered read data and single-cycle acknowledge.
// Signals:
//   dev_sel   NIC slave select
//   wb_cyc    bus cycle active
//   wb_we     1 = write
//   wb_adr    word address (ADDR_WIDTH bits)
//   wb_dat_w  write data (full words only)
//   wb_dat_r  read data, valid with wb_ack
//   wb_ack    single-cycle acknowledge
interface wb_timer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  dev_sel;
  logic                  wb_cyc;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [31:0]           wb_dat_w;
  logic [31:0]           wb_dat_r;
  logic                  wb_ack;

  modport master (
    output dev_sel, wb_cyc, wb_we, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack
  );

  modport slave (
    input  dev_sel, wb_cyc, wb_we, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack
  );
endinterface

// File: rtl/wb_timer_presc.sv
// wb_timer_presc
// Purpose: prescaler for wb_timer. Counts enabled cycles and emits a one-cycle
//          tick every (reload_val + 1) cycles; reload_val = 0 ticks every cycle.
// Ports:
//   i_clk       system clock
//   i_reset_n   asynchronous active-low reset
//   en          count enable; while low the counter is held at 0, no ticks
//   reload_val  divisor minus one
//   clr         restart the division from 0 (used when the divisor is rewritten)
//   tick        combinational tick, high in the cycle the counter wraps
module wb_timer_presc #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] reload_val,
  input  logic                   clr,
  output logic                   tick
);

  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] cnt_reg;
  logic [PRESC_WIDTH-1:0] cnt_next;
  logic                   at_reload;

  assign at_reload = (cnt_reg == reload_val);
  assign tick      = en & at_reload;

  // A clear restarts the division even if the counter is currently beyond a
  // smaller new divisor, so it can never run the long way round.
  always_comb begin
    cnt_next = cnt_reg;
    if (!en || clr || at_reload) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + PRESC_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// wb_timer
// Purpose: Wishbone slave timer for NIC slave slot 2. Prescaled 64-bit
//          up-counter, 64-bit compare, sticky MATCH flag, level interrupt and
//          an atomic 64-bit read through a shadow of the upper count half.
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset, clears every flop
//   bus        slave side of wb_timer_if (select/cyc/we/adr/wdata in,
//              rdata/ack out)
//   o_irq      registered level interrupt, IRQ_EN & MATCH
// Register map (word index = adr[2:0], upper bits ignored):
//   0 CTRL  [0] EN [1] IRQ_EN [2] AUTO_RELOAD
//   1 PRESC divisor minus one
//   2 COUNT_LO (read also latches COUNT[63:32] into the shadow)
//   3 COUNT_HI (read returns shadow, write goes to live count)
//   4 CMP_LO   5 CMP_HI
//   6 STATUS [0] MATCH, write 1 to clear
//   7 reads 0, writes ignored
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int PRESC_WIDTH = 16,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  wb_timer_if.slave    bus,
  output logic         o_irq
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   ack_reg,    ack_next;
  logic [31:0]            dat_reg,    dat_next;
  logic                   irq_reg,    irq_next;
  ctrl_t                  ctrl_reg,   ctrl_next;
  logic [PRESC_WIDTH-1:0] presc_reg,  presc_next;
  logic [63:0]            count_reg,  count_next;
  logic [63:0]            cmp_reg,    cmp_next;
  logic [31:0]            shadow_reg, shadow_next;
  logic                   match_reg,  match_next;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        req;
  logic        wr;
  logic        rd;
  reg_idx_e    idx;
  logic [31:0] wdat;
  logic [31:0] rdata;

  // An access is taken only when no ack is outstanding; a request held high
  // is therefore served every second cycle.
  assign req  = bus.dev_sel & bus.wb_cyc & ~ack_reg;
  assign wr   = req &  bus.wb_we;
  assign rd   = req & ~bus.wb_we;
  assign idx  = reg_idx_e'(bus.wb_adr[2:0]);
  assign wdat = bus.wb_dat_w;

  // Address bits above the 8-word window are decoded by the NIC, not here.
  logic unused_adr;
  assign unused_adr = &{1'b0, bus.wb_adr[ADDR_WIDTH-1:3]};

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick;
  logic presc_clr;

  assign presc_clr = wr & (idx == IDX_PRESC);

  wb_timer_presc #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .en         (ctrl_reg.en),
    .reload_val (presc_reg),
    .clr        (presc_clr),
    .tick       (tick)
  );

  // ---------------------------------------------------------------------------
  // Read mux (current register values)
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:     rdata = ctrl_word(ctrl_reg);
      IDX_PRESC:    rdata = 32'(presc_reg);
      IDX_COUNT_LO: rdata = count_reg[31:0];
      IDX_COUNT_HI: rdata = shadow_reg;
      IDX_CMP_LO:   rdata = cmp_reg[31:0];
      IDX_CMP_HI:   rdata = cmp_reg[63:32];
      IDX_STATUS:   rdata[STATUS_MATCH_BIT] = match_reg;
      IDX_RSVD:     rdata = '0;
      default:      rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic hit;
  logic match_clr;

  assign hit       = (count_reg == cmp_reg);
  assign match_clr = wr & (idx == IDX_STATUS) & wdat[STATUS_MATCH_BIT];

  always_comb begin
    ack_next    = req;
    dat_next    = dat_reg;
    shadow_next = shadow_reg;
    ctrl_next   = ctrl_reg;
    presc_next  = presc_reg;
    cmp_next    = cmp_reg;
    count_next  = count_reg;

    if (req) begin
      dat_next = rdata;
    end

    // Latching the upper half on a COUNT_LO read makes LO-then-HI an
    // atomic 64-bit snapshot.
    if (rd && (idx == IDX_COUNT_LO)) begin
      shadow_next = count_reg[63:32];
    end

    if (tick) begin
      if (ctrl_reg.auto_reload && hit) begin
        count_next = '0;
      end else begin
        count_next = count_reg + 64'd1;
      end
    end

    // A software write to either count half overrides the tick for the whole
    // 64-bit value: the other half keeps its old contents and no carry moves.
    if (wr) begin
      case (idx)
        IDX_CTRL:     ctrl_next  = ctrl_t'(wdat[2:0]);
        IDX_PRESC:    presc_next = wdat[PRESC_WIDTH-1:0];
        IDX_COUNT_LO: count_next = {count_reg[63:32], wdat};
        IDX_COUNT_HI: count_next = {wdat, count_reg[31:0]};
        IDX_CMP_LO:   cmp_next   = {cmp_reg[63:32], wdat};
        IDX_CMP_HI:   cmp_next   = {wdat, cmp_reg[31:0]};
        default:      ;
      endcase
    end

    // Compare uses the pre-update count; a set in the same cycle as a
    // write-1-to-clear wins.
    match_next = (tick & hit) | (match_reg & ~match_clr);

    irq_next = ctrl_reg.irq_en & match_reg;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      irq_reg    <= 1'b0;
      ctrl_reg   <= '0;
      presc_reg  <= '0;
      count_reg  <= '0;
      cmp_reg    <= CMP_RESET;
      shadow_reg <= '0;
      match_reg  <= 1'b0;
    end else begin
      ack_reg    <= ack_next;
      dat_reg    <= dat_next;
      irq_reg    <= irq_next;
      ctrl_reg   <= ctrl_next;
      presc_reg  <= presc_next;
      count_reg  <= count_next;
      cmp_reg    <= cmp_next;
      shadow_reg <= shadow_next;
      match_reg  <= match_next;
    end
  end

  assign bus.wb_ack   = ack_reg;
  assign bus.wb_dat_r = dat_reg;
  assign o_irq        = irq_reg;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer
// Purpose: self-checking bench for wb_timer. Directed scenarios plus a
//          randomized register-access phase, all checked against a
//          behavioural model of the timer kept in this file.
module tb_wb_timer;

  logic clk;
  logic rst_n;
  logic irq;

  int tests;
  int fails;

  wb_timer_if #(.ADDR_WIDTH(10)) bus ();

  wb_timer #(
    .PRESC_WIDTH (16),
    .ADDR_WIDTH  (10)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: timer state advanced once per rising edge
  // ---------------------------------------------------------------------------
  logic [2:0]        m_ctrl;    // {auto_reload, irq_en, en}
  logic [15:0]       m_presc;
  longint unsigned   m_elapsed; // enabled cycles since the divider restarted
  logic [63:0]       m_count;
  logic [63:0]       m_cmp;
  logic              m_match;
  logic              m_irq;
  logic [31:0]       m_shadow;
  logic              m_ack;
  logic [31:0]       m_dat;

  task automatic model_reset();
    m_ctrl    = '0;
    m_presc   = '0;
    m_elapsed = 0;
    m_count   = '0;
    m_cmp     = '1;
    m_match   = 1'b0;
    m_irq     = 1'b0;
    m_shadow  = '0;
    m_ack     = 1'b0;
    m_dat     = '0;
  endtask

  task automatic model_step();
    bit              take;
    bit              wr;
    bit              tick;
    bit              same;
    logic [2:0]      i;
    logic [31:0]     d;
    logic [31:0]     view;
    logic [63:0]     cnt_n;
    longint unsigned period;
    take   = bus.dev_sel && bus.wb_cyc && !m_ack;
    wr     = take && bus.wb_we;
    i      = bus.wb_adr[2:0];
    d      = bus.wb_dat_w;
    period = longint'(m_presc) + 1;
    // One tick at the end of each completed divisor period.
    tick   = m_ctrl[0] && ((m_elapsed % period) == period - 1);
    same   = (m_count == m_cmp);

    case (i)
      3'd0:    view = {29'd0, m_ctrl};
      3'd1:    view = {16'd0, m_presc};
      3'd2:    view = m_count[31:0];
      3'd3:    view = m_shadow;
      3'd4:    view = m_cmp[31:0];
      3'd5:    view = m_cmp[63:32];
      3'd6:    view = {31'd0, m_match};
      default: view = 32'd0;
    endcase

    cnt_n = m_count;
    if (tick) cnt_n = (m_ctrl[2] && same) ? 64'd0 : m_count + 64'd1;
    if (wr && i == 3'd2) cnt_n = {m_count[63:32], d};
    if (wr && i == 3'd3) cnt_n = {d, m_count[31:0]};

    m_irq   = m_ctrl[1] && m_match;
    m_match = (tick && same) || (m_match && !(wr && i == 3'd6 && d[0]));
    if (take && !bus.wb_we && i == 3'd2) m_shadow = m_count[63:32];
    if (take) m_dat = view;
    m_ack   = take;
    m_count = cnt_n;

    if (!m_ctrl[0] || (wr && i == 3'd1)) m_elapsed = 0;
    else m_elapsed = m_elapsed + 1;

    if (wr && i == 3'd0) m_ctrl  = d[2:0];
    if (wr && i == 3'd1) m_presc = d[15:0];
    if (wr && i == 3'd4) m_cmp   = {m_cmp[63:32], d};
    if (wr && i == 3'd5) m_cmp   = {d, m_cmp[31:0]};
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the rising edge, outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    chk("irq", {63'd0, irq}, {63'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Idle cycle with a partial (ignored) request: select without cyc or vice versa.
  task automatic idle_noise();
    int r;
    r = $urandom_range(2, 0);
    bus.dev_sel = (r == 1);
    bus.wb_cyc  = (r == 2);
    step();
    bus.dev_sel = 1'b0;
    bus.wb_cyc  = 1'b0;
  endtask

  // Single access; called at a falling edge, returns at a falling edge.
  task automatic xfer(input bit we, input logic [2:0] idx, input logic [31:0] wd,
                      input string tag, output logic [31:0] rdv);
    logic [6:0] upper;
    upper = 7'($urandom_range(127, 0));
    chk({tag, "_ack_idle"}, {63'd0, bus.wb_ack}, 64'd0);
    bus.dev_sel  = 1'b1;
    bus.wb_cyc   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = {upper, idx};
    bus.wb_dat_w = wd;
    step();
    chk({tag, "_ack"}, {63'd0, bus.wb_ack}, 64'd1);
    rdv = bus.wb_dat_r;
    if (!we) chk(tag, {32'd0, rdv}, {32'd0, m_dat});
    $display("[TB] %0t %s %s idx=%0d data=%08h", $time, tag, we ? "WR" : "RD", idx,
             we ? wd : rdv);
    bus.dev_sel = 1'b0;
    bus.wb_cyc  = 1'b0;
    bus.wb_we   = 1'b0;
    step();
    chk({tag, "_ack_drop"}, {63'd0, bus.wb_ack}, 64'd0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input string tag);
    logic [31:0] unused_rd;
    xfer(1'b1, idx, wd, tag, unused_rd);
  endtask

  task automatic rd(input logic [2:0] idx, input string tag, output logic [31:0] rdv);
    xfer(1'b0, idx, 32'd0, tag, rdv);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] rst_vals [8];
  logic [31:0] v;
  logic [31:0] v2;
  logic [31:0] wd;
  logic [2:0]  ridx;
  bit          rwe;

  initial begin
    tests = 0;
    fails = 0;
    rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus.dev_sel  = 1'b0;
    bus.wb_cyc   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_dat_w = '0;
    rst_n = 1'b0;
    model_reset();

    // Reset state
    idle(3);
    chk("rst_ack", {63'd0, bus.wb_ack}, 64'd0);
    chk("rst_dat", {32'd0, bus.wb_dat_r}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Readback of every register after reset
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), "rst_read", v);
      chk("rst_value", {32'd0, v}, {32'd0, rst_vals[i]});
    end

    // Prescaled count: divisor 4
    wr(3'd1, 32'd3, "presc");
    wr(3'd0, 32'd1, "ctrl_en");
    idle(40);
    rd(3'd2, "presc_cnt", v);
    idle(2);
    rd(3'd2, "presc_cnt2", v2);
    chk("presc_rate", {32'd0, v2 - v}, 64'd1);

    // Compare and interrupt
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd2, 32'd0, "cnt_lo");
    wr(3'd3, 32'd0, "cnt_hi");
    wr(3'd6, 32'd1, "st_clr");
    wr(3'd5, 32'd0, "cmp_hi");
    wr(3'd4, 32'd5, "cmp_lo");
    wr(3'd1, 32'd0, "presc0");
    wr(3'd0, 32'd3, "ctrl_irq");
    idle(12);
    chk("irq_on", {63'd0, irq}, 64'd1);
    rd(3'd6, "status_set", v);
    chk("match_set", {32'd0, v}, 64'd1);
    wr(3'd6, 32'd1, "st_w1c");
    idle(3);
    chk("irq_off", {63'd0, irq}, 64'd0);

    // Auto-reload with CMP = 2
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd2, 32'd0, "cnt_lo");
    wr(3'd6, 32'd1, "st_clr");
    wr(3'd4, 32'd2, "cmp_lo");
    wr(3'd0, 32'd5, "ctrl_ar");
    for (int i = 0; i < 6; i++) begin
      rd(3'd2, "ar_cnt", v);
      chk("ar_range", {63'd0, v <= 32'd2}, 64'd1);
    end
    rd(3'd6, "ar_match", v);
    chk("ar_match_set", {32'd0, v}, 64'd1);

    // Carry into the upper half and shadow read
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd3, 32'd0, "cnt_hi");
    wr(3'd2, 32'hFFFF_FFFE, "cnt_lo");
    wr(3'd0, 32'd1, "ctrl_en");
    idle(2);
    rd(3'd2, "carry_lo", v);
    chk("carry_lo_val", {32'd0, v}, 64'd1);
    idle(10);
    rd(3'd3, "carry_hi", v);
    chk("carry_hi_val", {32'd0, v}, 64'd1);

    // Write to COUNT_LO in a tick cycle: written value, no increment then
    wr(3'd2, 32'h100, "col_lo");
    rd(3'd2, "col_rd", v);
    chk("col_lo_val", {32'd0, v}, 64'h101);

    // Re-arm the interrupt, then reset in the middle of an access
    wr(3'd4, 32'd1, "cmp_lo");
    wr(3'd2, 32'd0, "cnt_lo");
    wr(3'd3, 32'd0, "cnt_hi");
    wr(3'd0, 32'd7, "ctrl_all");
    idle(6);
    bus.dev_sel = 1'b1;
    bus.wb_cyc  = 1'b1;
    bus.wb_we   = 1'b0;
    bus.wb_adr  = 10'd2;
    step();
    chk("pre_rst_ack", {63'd0, bus.wb_ack}, 64'd1);
    chk("pre_rst_irq", {63'd0, irq}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {63'd0, bus.wb_ack}, 64'd0);
    chk("mid_rst_irq", {63'd0, irq}, 64'd0);
    chk("mid_rst_dat", {32'd0, bus.wb_dat_r}, 64'd0);
    model_reset();
    bus.dev_sel = 1'b0;
    bus.wb_cyc  = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd(3'd4, "post_rst_cmp", v);
    chk("post_rst_cmp_val", {32'd0, v}, 64'hFFFF_FFFF);

    // MATCH set and write-1-to-clear in the same cycle: set wins
    wr(3'd5, 32'd0, "cmp_hi");
    wr(3'd4, 32'h201, "cmp_lo");
    wr(3'd1, 32'd0, "presc0");
    wr(3'd0, 32'd1, "ctrl_en");
    wr(3'd2, 32'h200, "cnt_lo");
    wr(3'd6, 32'd1, "st_col");
    rd(3'd6, "st_col_rd", v);
    chk("set_wins", {32'd0, v}, 64'd1);

    // Randomized register traffic
    for (int n = 0; n < 80; n++) begin
      ridx = 3'($urandom_range(7, 0));
      rwe  = 1'($urandom_range(1, 0));
      case (ridx)
        3'd0:    wd = 32'($urandom_range(7, 0));
        3'd1:    wd = 32'($urandom_range(3, 0));
        3'd2:    wd = 32'($urandom_range(30, 0));
        3'd3:    wd = 32'($urandom_range(1, 0));
        3'd4:    wd = 32'($urandom_range(30, 0));
        3'd5:    wd = 32'($urandom_range(1, 0));
        default: wd = $urandom;
      endcase
      xfer(rwe, ridx, wd, "rnd", v);
      for (int k = 0; k < int'($urandom_range(4, 0)); k++) idle_noise();
    end

    // Final readback of every register against the model
    for (int i = 0; i < 8; i++) rd(3'(i), "final", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
